// File: rtl/snn_config_loader.sv
// Byte-serial configuration loader for the SNN top: fills packed weights, delay
// fields and neuron parameters from a stream of bytes, then flags config_done.
module snn_config_loader #(
  parameter int WEIGHT_BYTES = 52,
  parameter int DELAY_BYTES  = 104,
  parameter int TOTAL_BYTES  = WEIGHT_BYTES + DELAY_BYTES + 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  output logic [WEIGHT_BYTES*8-1:0] weights,
  output logic [DELAY_BYTES*8-1:0]  delays,
  output logic [5:0]                threshold,
  output logic [5:0]                decay,
  output logic [5:0]                refractory_period,
  output logic                      busy,
  output logic                      config_done,
  output logic [7:0]                byte_count
);

  localparam int W_BITS = WEIGHT_BYTES * 8;
  localparam int D_BITS = DELAY_BYTES * 8;
  localparam int WIW    = $clog2(W_BITS);
  localparam int DIW    = $clog2(D_BITS);

  localparam logic [7:0] W_END  = 8'(WEIGHT_BYTES);
  localparam logic [7:0] D_END  = 8'(WEIGHT_BYTES + DELAY_BYTES);
  localparam logic [7:0] T_IDX  = 8'(TOTAL_BYTES - 3);
  localparam logic [7:0] DC_IDX = 8'(TOTAL_BYTES - 2);
  localparam logic [7:0] R_IDX  = 8'(TOTAL_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state, next_state;
  logic             accept;
  logic [7:0]       d_byte;
  logic [WIW-1:0]   w_sel;
  logic [DIW-1:0]   d_sel;

  assign data_ready  = (state == LOAD) && !start;
  assign accept      = data_valid && data_ready;
  assign busy        = (state == LOAD);
  assign config_done = (state == DONE);

  // Bit offsets of the current byte within the weight and delay vectors.
  assign d_byte = byte_count - W_END;
  assign w_sel  = WIW'({byte_count, 3'b000});
  assign d_sel  = DIW'({d_byte, 3'b000});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: if (accept && byte_count == R_IDX) next_state = DONE;
      DONE: if (start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // Start always wins over a concurrent byte, so a restart never absorbs stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count        <= '0;
      weights           <= '0;
      delays            <= '0;
      threshold         <= '0;
      decay             <= '0;
      refractory_period <= '0;
    end else if (start) begin
      byte_count <= '0;
    end else if (accept) begin
      byte_count <= byte_count + 8'd1;
      if (byte_count < W_END)       weights[w_sel +: 8] <= data_in;
      else if (byte_count < D_END)  delays[d_sel +: 8]  <= data_in;
      else if (byte_count == T_IDX) threshold           <= data_in[5:0];
      else if (byte_count == DC_IDX) decay              <= data_in[5:0];
      else                          refractory_period   <= data_in[5:0];
    end
  end

endmodule

// File: tb/tb_snn_config_loader.sv
// Directed self-checking bench for snn_config_loader with a small byte-level
// scoreboard of the expected configuration fields.
module tb_snn_config_loader;

  logic         clk = 0;
  logic         reset = 0;
  logic         start = 0;
  logic [7:0]   data_in = 0;
  logic         data_valid = 0;
  logic         data_ready;
  logic [415:0] weights;
  logic [831:0] delays;
  logic [5:0]   threshold, decay, refractory_period;
  logic         busy, config_done;
  logic [7:0]   byte_count;

  int errors = 0;
  int checks = 0;

  logic [415:0] exp_w;
  logic [831:0] exp_d;
  logic [5:0]   exp_t, exp_dc, exp_r;
  int           exp_cnt;
  bit           exp_loading;

  snn_config_loader dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .weights(weights),
    .delays(delays), .threshold(threshold), .decay(decay),
    .refractory_period(refractory_period), .busy(busy),
    .config_done(config_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [831:0] actual, input logic [831:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic model_clear();
    exp_w = '0; exp_d = '0; exp_t = '0; exp_dc = '0; exp_r = '0;
    exp_cnt = 0; exp_loading = 0;
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, ".weights"}, weights, exp_w);
    checkOutput({tag, ".delays"}, delays, exp_d);
    checkOutput({tag, ".threshold"}, threshold, exp_t);
    checkOutput({tag, ".decay"}, decay, exp_dc);
    checkOutput({tag, ".refractory"}, refractory_period, exp_r);
    checkOutput({tag, ".byte_count"}, byte_count, exp_cnt);
  endtask

  // One cycle with start high; optionally a competing valid byte that must be dropped.
  task automatic pulse_start(input bit with_valid, input logic [7:0] b);
    start = 1; data_valid = with_valid; data_in = b;
    #1 checkOutput("ready_low_during_start", data_ready, 0);
    @(posedge clk); #1;
    start = 0; data_valid = 0;
    exp_cnt = 0; exp_loading = 1;
  endtask

  // Present one byte for one cycle and update the scoreboard if it should be taken.
  task automatic applyStimulus(input logic [7:0] b);
    data_valid = 1; data_in = b;
    @(posedge clk); #1;
    data_valid = 0;
    if (exp_loading) begin
      if (exp_cnt < 52)       exp_w[exp_cnt*8 +: 8] = b;
      else if (exp_cnt < 156) exp_d[(exp_cnt-52)*8 +: 8] = b;
      else if (exp_cnt == 156) exp_t = b[5:0];
      else if (exp_cnt == 157) exp_dc = b[5:0];
      else                     exp_r = b[5:0];
      exp_cnt++;
      if (exp_cnt == 159) exp_loading = 0;
    end
  endtask

  task automatic check_index_pattern(input string tag);
    checkOutput({tag, ".w_lo"}, weights[7:0], 8'h00);
    checkOutput({tag, ".w_hi"}, weights[415:408], 8'h33);
    checkOutput({tag, ".d_lo"}, delays[7:0], 8'h34);
    checkOutput({tag, ".d_hi"}, delays[831:824], 8'h9B);
    checkOutput({tag, ".thr"}, threshold, 6'h1C);
    checkOutput({tag, ".dec"}, decay, 6'h1D);
    checkOutput({tag, ".ref"}, refractory_period, 6'h1E);
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    reset = 1;
    #1;
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.done", config_done, 0);
    checkOutput("rst.ready", data_ready, 0);
    check_all("rst");
    @(posedge clk); #1 reset = 0;
    @(posedge clk); #1;

    // Back-to-back index-pattern load.
    pulse_start(0, 8'h00);
    checkOutput("start.busy", busy, 1);
    checkOutput("start.done", config_done, 0);
    checkOutput("start.count", byte_count, 0);
    for (int k = 0; k < 158; k++) applyStimulus(8'(k));
    checkOutput("pre_last.done", config_done, 0);
    checkOutput("pre_last.count", byte_count, 158);
    applyStimulus(8'd158);
    checkOutput("last.done", config_done, 1);
    checkOutput("last.busy", busy, 0);
    checkOutput("last.count", byte_count, 159);
    check_index_pattern("b2b");
    check_all("b2b");

    // Bytes offered in DONE are ignored.
    for (int k = 0; k < 10; k++) begin
      data_valid = 1; data_in = 8'hEE;
      #1 if (k == 0) checkOutput("done.ready", data_ready, 0);
      @(posedge clk); #1 data_valid = 0;
    end
    checkOutput("done_ign.done", config_done, 1);
    check_all("done_ign");

    // Restart from DONE retains old fields until overwritten.
    pulse_start(0, 8'h00);
    checkOutput("redo.done", config_done, 0);
    checkOutput("redo.busy", busy, 1);
    check_all("redo_retain");
    for (int k = 0; k < 10; k++) applyStimulus(8'hFF);
    check_all("redo_partial");

    // Restart inside LOAD, then load on alternate cycles.
    pulse_start(0, 8'h00);
    checkOutput("alt.count0", byte_count, 0);
    for (int k = 0; k < 159; k++) begin
      applyStimulus(8'(k));
      @(posedge clk); #1;
      if (k % 40 == 0) checkOutput($sformatf("alt.stall_count%0d", k), byte_count, 8'(k + 1));
    end
    checkOutput("alt.done", config_done, 1);
    check_index_pattern("alt");
    check_all("alt");

    // 80 bytes, start with a concurrent byte, then a full 0xA5 load.
    pulse_start(0, 8'h00);
    for (int k = 0; k < 80; k++) applyStimulus(8'(k + 3));
    checkOutput("mid.count", byte_count, 80);
    pulse_start(1, 8'h5A);
    checkOutput("drop.count", byte_count, 0);
    for (int k = 0; k < 159; k++) applyStimulus(8'hA5);
    checkOutput("a5.weights", weights, {52{8'hA5}});
    checkOutput("a5.delays", delays, {104{8'hA5}});
    checkOutput("a5.thr", threshold, 6'h25);
    checkOutput("a5.dec", decay, 6'h25);
    checkOutput("a5.ref", refractory_period, 6'h25);
    checkOutput("a5.done", config_done, 1);

    // Reset in the middle of a load clears everything without a clock edge.
    pulse_start(0, 8'h00);
    for (int k = 0; k < 100; k++) applyStimulus(8'(k + 7));
    reset = 1;
    #1;
    model_clear();
    checkOutput("mid_rst.busy", busy, 0);
    checkOutput("mid_rst.ready", data_ready, 0);
    check_all("mid_rst");
    @(posedge clk); #1 reset = 0;
    for (int k = 0; k < 5; k++) applyStimulus(8'h77);
    checkOutput("idle.busy", busy, 0);
    checkOutput("idle.done", config_done, 0);
    check_all("idle_ign");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
